// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial fetch/load/store controller for an 8-bit RAM; load/store wins over fetch.
// Define MEM_CTRL_LOAD_SEXT_EN to sign-extend byte/half loads when mem_sext is set.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_size,
    input  logic        mem_sext,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        stall_if,
    output logic        stall_mem,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    input  logic [7:0]  ram_din
);
    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;
    state_t      r_state;
    logic [31:0] r_ram_addr, r_if_data, r_mem_rdata;
    logic [23:0] r_buf, r_wd;
    logic [7:0]  r_ram_dout;
    logic [2:0]  r_n, r_cnt;
    logic        r_ram_we, r_if_done, r_mem_done, r_sext;
    logic [2:0]  w_n;
    logic [31:0] w_sh, w_rdata;
    logic        w_sb;
    assign w_n = mem_size == 2'b00 ? 3'd1 : mem_size == 2'b01 ? 3'd2 : 3'd4;
    // Bytes shift in from the top, so a byte or half sits in the upper lanes with its sign in bit 31.
    assign w_sh = {ram_din, r_buf};
`ifdef MEM_CTRL_LOAD_SEXT_EN
    assign w_sb = r_sext & w_sh[31];
`else
    assign w_sb = r_sext & 1'b0;
`endif
    assign w_rdata = r_n == 3'd1 ? {{24{w_sb}}, w_sh[31:24]} :
                     r_n == 3'd2 ? {{16{w_sb}}, w_sh[31:16]} : w_sh;
    assign if_data   = r_if_data;
    assign if_done   = r_if_done;
    assign mem_rdata = r_mem_rdata;
    assign mem_done  = r_mem_done;
    assign ram_addr  = r_ram_addr;
    assign ram_dout  = r_ram_dout;
    assign ram_we    = r_ram_we;
    assign stall_if  = if_req & ~r_if_done;
    assign stall_mem = mem_req & ~r_mem_done;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ram_addr  <= '0;
            r_ram_dout  <= '0;
            r_ram_we    <= 1'b0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_buf       <= '0;
            r_wd        <= '0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_sext      <= 1'b0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (mem_req) begin
                        r_ram_addr <= mem_addr;
                        r_n        <= w_n;
                        r_sext     <= mem_sext;
                        r_state    <= mem_we ? MEM_WR : MEM_RD;
                        r_ram_we   <= mem_we;
                        r_ram_dout <= mem_wdata[7:0];
                        r_wd       <= mem_wdata[31:8];
                    end else if (if_req) begin
                        r_ram_addr <= if_addr;
                        r_n        <= 3'd4;
                        r_state    <= IF_RD;
                    end
                end
                IF_RD, MEM_RD: begin
                    // Read data lags its address by one cycle, so capture runs one step behind r_cnt.
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt + 3'd1 < r_n)
                        r_ram_addr <= r_ram_addr + 32'd1;
                    if (r_cnt != 3'd0)
                        r_buf <= w_sh[31:8];
                    if (r_cnt == r_n) begin
                        r_state <= DONE;
                        if (r_state == IF_RD) begin
                            r_if_data <= w_sh;
                            r_if_done <= 1'b1;
                        end else begin
                            r_mem_rdata <= w_rdata;
                            r_mem_done  <= 1'b1;
                        end
                    end
                end
                MEM_WR: begin
                    if (r_cnt == r_n - 3'd1) begin
                        r_state    <= DONE;
                        r_ram_we   <= 1'b0;
                        r_mem_done <= 1'b1;
                    end else begin
                        r_cnt      <= r_cnt + 3'd1;
                        r_ram_addr <= r_ram_addr + 32'd1;
                        r_ram_dout <= r_wd[7:0];
                        r_wd       <= {8'h00, r_wd[23:8]};
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vectors against a cycle-level transaction model of mem_ctrl plus a byte RAM.
module tb_mem_ctrl;
`ifdef MEM_CTRL_LOAD_SEXT_EN
    localparam bit SEXT = 1'b1;
`else
    localparam bit SEXT = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1, if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, mem_sext = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [1:0]  mem_size = '0;
    logic [7:0]  ram_din = '0;
    logic [31:0] if_data, mem_rdata, ram_addr;
    logic        if_done, mem_done, stall_if, stall_mem, ram_we;
    logic [7:0]  ram_dout;
    int vectors = 0, miscompares = 0;
    bit chk_en = 1'b0;
    logic [7:0] ram [0:511];
    bit wr_v [0:511];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_sext(mem_sext), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stall_if(stall_if), .stall_mem(stall_mem), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .ram_we(ram_we), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            32'h010: return 8'h80;
            32'h020: return 8'h84;
            32'h021: return 8'h97;
            32'h022: return 8'hF1;
            32'h023: return 8'h5A;
            default: return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return wr_v[a[8:0]] ? ram[a[8:0]] : init_byte(a);
    endfunction

    always @(posedge clk) begin
        ram_din <= rd_byte(ram_addr);
        if (ram_we) begin
            ram[ram_addr[8:0]]  <= ram_dout;
            wr_v[ram_addr[8:0]] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: m_k counts cycles since the accepting edge (first driven cycle is k=1).
    bit m_act = 1'b0, m_wr = 1'b0, m_if = 1'b0;
    int m_k = 0, m_n = 0, m_dk = 0;
    logic [31:0] m_base = '0, m_wd = '0, m_rd = '0, exp_if_data = '0, exp_mem_rdata = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0;
            exp_if_data = '0;
            exp_mem_rdata = '0;
        end else if (m_act) begin
            m_k++;
            if (m_k > m_dk)
                m_act = 1'b0;
            else if (m_k == m_dk && !m_wr) begin
                if (m_if) exp_if_data = m_rd;
                else exp_mem_rdata = m_rd;
            end
        end else if (mem_req || if_req) begin
            m_act  = 1'b1;
            m_k    = 1;
            m_if   = !mem_req;
            m_wr   = mem_req && mem_we;
            m_base = m_if ? if_addr : mem_addr;
            m_n    = m_if ? 4 : mem_size == 2'b00 ? 1 : mem_size == 2'b01 ? 2 : 4;
            m_dk   = m_wr ? m_n + 1 : m_n + 2;
            m_wd   = mem_wdata;
            m_rd   = '0;
            for (int i = 0; i < m_n; i++)
                m_rd = m_rd | (32'(rd_byte(m_base + 32'(i))) << (8 * i));
            if (SEXT && !m_if && mem_sext && m_n == 1 && m_rd[7]) m_rd = m_rd | 32'hFFFFFF00;
            if (SEXT && !m_if && mem_sext && m_n == 2 && m_rd[15]) m_rd = m_rd | 32'hFFFF0000;
        end
    end

    always @(negedge clk) begin
        logic eif, emem, ewe;
        if (chk_en) begin
            eif  = m_act && m_if && m_k == m_dk;
            emem = m_act && !m_if && m_k == m_dk;
            ewe  = m_act && m_wr && m_k <= m_n;
            chk("ram_we", ram_we, ewe);
            chk("if_done", if_done, eif);
            chk("mem_done", mem_done, emem);
            chk("if_data", if_data, exp_if_data);
            chk("mem_rdata", mem_rdata, exp_mem_rdata);
            chk("stall_if", stall_if, if_req & ~eif);
            chk("stall_mem", stall_mem, mem_req & ~emem);
            if (m_act && m_k <= m_n) begin
                chk("ram_addr", ram_addr, m_base + 32'(m_k - 1));
                if (m_wr) chk("ram_dout", ram_dout, (m_wd >> (8 * (m_k - 1))) & 32'hFF);
            end
        end
    end

    task automatic wait_done(input bit is_if, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_if ? if_done : mem_done) && n < 30);
        if (is_if) chk("if_done_seen", if_done, 1);
        else chk("mem_done_seen", mem_done, 1);
    endtask

    task automatic mem_op(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input logic sx, input int lat, input logic [31:0] exp, input string nm);
        int n;
        mem_we = we; mem_addr = a; mem_wdata = d; mem_size = sz; mem_sext = sx; mem_req = 1'b1;
        wait_done(1'b0, n);
        chk({nm, "_lat"}, n, lat);
        if (!we) chk(nm, mem_rdata, exp);
        @(posedge clk); #2;
        mem_req = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input string nm);
        int n;
        if_addr = a; if_req = 1'b1;
        wait_done(1'b1, n);
        chk({nm, "_lat"}, n, 7);
        chk(nm, if_data, exp);
        @(posedge clk); #2;
        if_req = 1'b0;
    endtask

    initial begin
        int n;
        @(posedge clk); #2;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_dout", ram_dout, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        fetch(32'h100, 32'h00100513, "fetch_100");
        mem_op(1'b1, 32'h200, 32'hDEADBEEF, 2'b10, 1'b0, 6, 0, "st_word_200");
        mem_op(1'b0, 32'h200, 0, 2'b10, 1'b0, 7, 32'hDEADBEEF, "ld_word_200");
        // Simultaneous requests: the load must complete before the fetch starts.
        if_addr = 32'h100; mem_we = 1'b0; mem_addr = 32'h10; mem_size = 2'b00; mem_sext = 1'b1;
        if_req = 1'b1; mem_req = 1'b1;
        wait_done(1'b0, n);
        chk("arb_ld_lat", n, 4);
        chk("arb_ld_data", mem_rdata, SEXT ? 32'hFFFFFF80 : 32'h00000080);
        @(posedge clk); #2;
        mem_req = 1'b0;
        wait_done(1'b1, n);
        chk("arb_if_lat", n, 7);
        chk("arb_if_data", if_data, 32'h00100513);
        @(posedge clk); #2;
        if_req = 1'b0;
        mem_op(1'b1, 32'hFFFFFFFF, 32'h1234ABCD, 2'b01, 1'b0, 4, 0, "st_half_wrap");
        mem_op(1'b0, 32'hFFFFFFFF, 0, 2'b01, 1'b1, 5, SEXT ? 32'hFFFFABCD : 32'h0000ABCD, "ld_half_wrap");
        mem_op(1'b0, 32'h20, 0, 2'b11, 1'b1, 7, 32'h5AF19784, "ld_size3");
        mem_op(1'b0, 32'h20, 0, 2'b01, 1'b0, 5, 32'h00009784, "ld_half_zext");
        mem_op(1'b0, 32'h21, 0, 2'b00, 1'b1, 4, SEXT ? 32'hFFFFFF97 : 32'h00000097, "ld_byte_sext");
        mem_op(1'b0, 32'h102, 0, 2'b10, 1'b0, 7, 32'hA0A10010, "ld_misaligned");
        // Request inputs change mid-store; the latched values must still be used.
        mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h11223344; mem_size = 2'b10; mem_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        mem_we = 1'b0; mem_addr = 32'h80; mem_wdata = '0; mem_size = 2'b00;
        wait_done(1'b0, n);
        chk("st_mid_lat", n, 4);
        @(posedge clk); #2;
        mem_req = 1'b0;
        mem_op(1'b0, 32'h40, 0, 2'b10, 1'b0, 7, 32'h11223344, "ld_word_40");
        mem_op(1'b1, 32'h41, 32'hFFFFFF77, 2'b00, 1'b0, 3, 0, "st_byte_41");
        mem_op(1'b0, 32'h40, 0, 2'b10, 1'b0, 7, 32'h11227744, "ld_word_40b");
        // Reset in cycle t0+2 of a word load aborts it.
        mem_we = 1'b0; mem_addr = 32'h100; mem_size = 2'b10; mem_sext = 1'b0; mem_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1; mem_req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ram_we", ram_we, 0);
        chk("abort_mem_rdata", mem_rdata, 0);
        chk("abort_if_data", if_data, 0);
        chk("abort_mem_done", mem_done, 0);
        repeat (6) @(negedge clk);
        @(posedge clk); #2;
        mem_op(1'b0, 32'h100, 0, 2'b10, 1'b0, 7, 32'h00100513, "ld_after_abort");
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: if_req  in  1  instruction fetch request, held until if_done.
REQ-004 SHALL: if_addr  in  32  fetch byte address.
REQ-005 SHALL: if_data  out  32  fetched word, valid with if_done.
REQ-006 SHALL: if_done  out  1  one-cycle completion pulse for fetch.
REQ-007 SHALL: mem_req  in  1  load/store request, held until mem_done.
REQ-008 SHALL: mem_we  in  1  1=store, 0=load.
REQ-009 SHALL: mem_addr  in  32  load/store byte address.
REQ-010 SHALL: mem_wdata  in  32  store data; low bytes used for byte/half.
REQ-011 SHALL: mem_size  in  2  00=byte, 01=half, 10=word; 11 treated as word.
REQ-012 SHALL: mem_sext  in  1  sign-extend load result.
REQ-013 SHALL: mem_rdata  out  32  load result, valid with mem_done.
REQ-014 SHALL: mem_done  out  1  one-cycle completion pulse for load/store.
REQ-015 SHALL: stall_if  out  1  stall request to pipeline controller, fetch pending.
REQ-016 SHALL: stall_mem  out  1  stall request to pipeline controller, load/store pending.
REQ-017 SHALL: ram_addr  out  32  byte address to 8-bit RAM.
REQ-018 SHALL: ram_dout  out  8  write byte to RAM.
REQ-019 SHALL: ram_we  out  1  RAM write enable.
REQ-020 SHALL: ram_din  in  8  RAM read byte; data for address of cycle k valid in cycle k+1.

Function
REQ-021 SHALL: FSM states IDLE, IF_RD, MEM_RD, MEM_WR, DONE; one access at a time.
REQ-022 SHALL: in IDLE, mem_req=1 wins over if_req=1; the losing request stays pending and stalled.
REQ-023 SHALL: access length N = 1/2/4 bytes for byte/half/word; fetch always N=4.
REQ-024 SHALL: request sampled in IDLE at edge t0; byte i address (base+i, 32-bit wrap) driven in cycle t0+1+i, little-endian.
REQ-025 SHALL: reads capture ram_din for byte i at end of cycle t0+2+i; done pulses in cycle t0+N+2.
REQ-026 SHALL: writes drive ram_we=1 and ram_dout=wdata byte i in cycle t0+1+i; done pulses in cycle t0+N+1; ram_we=0 otherwise.
REQ-027 SHALL: addr, size, we, wdata latched at t0; changes on request inputs mid-access ignored.
REQ-028 SHALL: DONE lasts exactly one cycle, then IDLE; a request still high in the following IDLE cycle starts a new access.
REQ-029 SHALL: stall_mem = mem_req & ~mem_done; stall_if = if_req & ~if_done; both combinational, same-cycle.
REQ-030 SHALL: if_data/mem_rdata hold last completed value until next completion of same port.
REQ-031 SHALL: no alignment check; misaligned accesses proceed byte-wise with address wrap at 2^32.

Reset
REQ-032 SHALL: on rst=1 at an edge: state=IDLE, ram_we=0, ram_addr=0, ram_dout=0, if_done=0, mem_done=0, if_data=0, mem_rdata=0.
REQ-033 SHALL: rst mid-access aborts with no done pulse; ram_we low from the next cycle.

Configuration
REQ-034 SHALL: with MEM_CTRL_LOAD_SEXT_EN defined, byte/half loads with mem_sext=1 sign-extend from bit 7/15; with mem_sext=0 zero-extend.
REQ-035 SHALL: without MEM_CTRL_LOAD_SEXT_EN, all loads zero-extend and mem_sext is ignored.

Verification
REQ-036 SHALL: fetch if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_addr 0x100..0x103, if_done in t0+6, if_data=0x00100513, stall_if high until if_done.
REQ-037 SHALL: store word 0xDEADBEEF at 0x200 -> ram_we=1 with bytes EF,BE,AD,DE at 0x200..0x203, mem_done in t0+5.
REQ-038 SHALL: simultaneous if_req and mem_req (load byte 0x80 at 0x10, sext=1) -> load first, mem_rdata=0xFFFFFF80 with macro (0x00000080 without), then fetch starts.
REQ-039 SHALL: half store at 0xFFFFFFFF -> bytes at 0xFFFFFFFF then 0x00000000.
REQ-040 SHALL: rst asserted in cycle t0+2 of word load -> no mem_done, state IDLE, ram_we=0, mem_rdata=0.
